// File: rtl/mem_axi_resp.sv
// mem_axi_resp: data-side memory request responder.
// Turns each accepted valid/addr_ok request into one single-beat AXI4 read
// (AR/R) or write (AW/W/B) and reports completion with a one-cycle data_ok.
// Only one transaction is in flight at a time.
module mem_axi_resp #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,

  // MEM-stage request side
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        req_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,

  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic                arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic                data_ok_d;
  logic                r_take_c, b_take_c;

  logic [ADDR_W-1:0]   addr_q;
  logic [SIZE_W-1:0]   size_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  // rid/rlast/bid carry nothing this block needs: single beat, fixed ID.
  logic                unused_axi_c;
  assign unused_axi_c = ^{rid, rlast, bid};

  // Request accepted only while idle and out of reset.
  assign req_addr_ok = reset & (state_q == IDLE) & req_valid;

  // Fixed single-beat INCR attributes and latched request payload.
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  // Response captures happen only while the matching ready is being driven.
  assign r_take_c = (state_q == RD_DATA) & rvalid;
  assign b_take_c = (state_q == WR_RESP) & bvalid;

  // State and write-channel completion flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next state, write-channel tracking and next values of the handshake outputs.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = req_we ? WR_REQ : RD_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) state_d = DONE;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q  | (wvalid & wready);
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (bvalid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    arvalid_d = (state_d == RD_ADDR);
    rready_d  = (state_d == RD_DATA);
    awvalid_d = (state_d == WR_REQ) & ~aw_done_d;
    wvalid_d  = (state_d == WR_REQ) & ~w_done_d;
    bready_d  = (state_d == WR_RESP);
    data_ok_d = (state_d == DONE);
  end

  // Registered AXI valid/ready and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      resp_data_ok <= 1'b0;
    end else begin
      arvalid      <= arvalid_d;
      rready       <= rready_d;
      awvalid      <= awvalid_d;
      wvalid       <= wvalid_d;
      bready       <= bready_d;
      resp_data_ok <= data_ok_d;
    end
  end

  // Request payload latched on accept; held stable for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (req_addr_ok) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      wstrb_q <= req_wstrb;
      wdata_q <= req_wdata;
    end
  end

  // Load data and error status captured on the R or B handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (r_take_c) begin
      resp_rdata <= rdata;
      resp_err   <= (rresp != 2'b00);
    end else if (b_take_c) begin
      resp_err   <= (bresp != 2'b00);
    end
  end

endmodule

// File: tb/tb_mem_axi_resp.sv
// Bench for mem_axi_resp: directed requests against a scripted AXI slave,
// a transaction-level model checked every cycle, plus literal latency pins.
module tb_mem_axi_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_addr_ok, resp_data_ok, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  mem_axi_resp #(.AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .req_addr_ok(req_addr_ok), .resp_data_ok(resp_data_ok),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave script, set by the directed tests.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  int          ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;

  // Transaction-level model: what is owed on each channel.
  bit          m_busy = 0, ar_owed = 0, r_owed = 0, aw_owed = 0, w_owed = 0;
  bit          b_owed = 0, ok_due = 0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0, e_rdata = 32'h0;
  logic [1:0]  p_size = 2'b00;
  logic [3:0]  p_wstrb = 4'h0;
  bit          p_we = 0, e_err = 0;

  // Observations of the DUT for literal latency checks.
  int          ok_cnt = 0, acc_cnt = 0, ok_cyc = 0, acc_cyc = 0, ar_cyc = 0, b_cyc = 0;
  int          wv_cycles = 0;
  logic [31:0] ok_rdata = 32'h0, ar_addr_rec = 32'h0;
  logic [2:0]  ar_sz_rec = 3'd0;
  logic        ok_err = 1'b0, arvalid_prev = 1'b0, bready_prev = 1'b0;

  // Per cycle: drive slave inputs, compare against model, advance model.
  initial begin
    forever begin
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs, acc;
      @(negedge clk);
      cyc++;

      if (!reset) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
      end else begin
        arready = ar_owed && (ar_n >= ar_wait); ar_n = ar_owed ? ar_n + 1 : 0;
        rvalid  = r_owed  && (r_n  >= r_wait);  r_n  = r_owed  ? r_n  + 1 : 0;
        awready = aw_owed && (aw_n >= aw_wait); aw_n = aw_owed ? aw_n + 1 : 0;
        wready  = w_owed  && (w_n  >= w_wait);  w_n  = w_owed  ? w_n  + 1 : 0;
        bvalid  = b_owed  && (b_n  >= b_wait);  b_n  = b_owed  ? b_n  + 1 : 0;
      end
      rdata = rvalid ? cfg_rdata : 32'h0;
      rresp = rvalid ? cfg_rresp : 2'b00;
      rid   = 4'd1;
      rlast = rvalid;
      bresp = bvalid ? cfg_bresp : 2'b00;
      bid   = 4'd1;
      #1;

      if (!reset) begin
        chk1("rst_addr_ok", req_addr_ok, 1'b0);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_data_ok", resp_data_ok, 1'b0);
        chk1("rst_err", resp_err, 1'b0);
        chk32("rst_rdata", resp_rdata, 32'h0);
      end else begin
        chk1("addr_ok", req_addr_ok, req_valid && !m_busy);
        chk1("arvalid", arvalid, ar_owed);
        chk1("rready", rready, r_owed);
        chk1("awvalid", awvalid, aw_owed);
        chk1("wvalid", wvalid, w_owed);
        chk1("bready", bready, b_owed);
        chk1("data_ok", resp_data_ok, ok_due);
        if (ar_owed) begin
          chk32("araddr", araddr, p_addr);
          chk32("arsize", 32'(arsize), 32'(p_size));
          chk32("arlen", 32'(arlen), 32'h0);
          chk32("arburst", 32'(arburst), 32'h1);
          chk32("arid", 32'(arid), 32'h1);
        end
        if (aw_owed) begin
          chk32("awaddr", awaddr, p_addr);
          chk32("awsize", 32'(awsize), 32'(p_size));
          chk32("awlen", 32'(awlen), 32'h0);
          chk32("awburst", 32'(awburst), 32'h1);
          chk32("awid", 32'(awid), 32'h1);
        end
        if (w_owed) begin
          chk32("wdata", wdata, p_wdata);
          chk32("wstrb", 32'(wstrb), 32'(p_wstrb));
          chk1("wlast", wlast, 1'b1);
        end
        if (ok_due) begin
          chk1("resp_err", resp_err, e_err);
          if (!p_we) chk32("resp_rdata", resp_rdata, e_rdata);
        end
      end

      if (req_addr_ok) begin acc_cnt++; acc_cyc = cyc; wv_cycles = 0; end
      if (resp_data_ok) begin
        ok_cnt++; ok_cyc = cyc; ok_rdata = resp_rdata; ok_err = resp_err;
      end
      if (arvalid && !arvalid_prev) begin
        ar_cyc = cyc; ar_addr_rec = araddr; ar_sz_rec = arsize;
      end
      if (wvalid) wv_cycles++;
      if (bready && !bready_prev) b_cyc = cyc;
      arvalid_prev = arvalid;
      bready_prev  = bready;

      if (!reset) begin
        m_busy = 0; ar_owed = 0; r_owed = 0; aw_owed = 0; w_owed = 0;
        b_owed = 0; ok_due = 0;
      end else begin
        acc   = req_valid && !m_busy;
        ar_hs = ar_owed && arready;
        r_hs  = r_owed  && rvalid;
        aw_hs = aw_owed && awready;
        w_hs  = w_owed  && wready;
        b_hs  = b_owed  && bvalid;
        if (ok_due) begin ok_due = 0; m_busy = 0; end
        if (ar_hs) begin ar_owed = 0; r_owed = 1; end
        if (r_hs) begin
          r_owed = 0; ok_due = 1; e_rdata = cfg_rdata; e_err = (cfg_rresp != 2'b00);
        end
        if (aw_hs) aw_owed = 0;
        if (w_hs)  w_owed = 0;
        if ((aw_hs || w_hs) && !aw_owed && !w_owed) b_owed = 1;
        if (b_hs) begin b_owed = 0; ok_due = 1; e_err = (cfg_bresp != 2'b00); end
        if (acc) begin
          m_busy = 1; p_addr = req_addr; p_we = req_we; p_size = req_size;
          p_wstrb = req_wstrb; p_wdata = req_wdata;
          if (req_we) begin aw_owed = 1; w_owed = 1; end
          else ar_owed = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] wd);
    req_addr = a; req_we = we; req_size = sz; req_wstrb = st; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic wait_acc(input int base);
    int n = 0;
    while (acc_cnt == base && n < 50) begin tick(); n++; end
    if (acc_cnt == base) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no addr_ok, expected one within 50 cycles");
    end
  endtask

  task automatic wait_ok(input int base);
    int n = 0;
    while (ok_cnt == base && n < 50) begin tick(); n++; end
    if (ok_cnt == base) begin
      n_checks++; n_fail++;
      $display("FAIL data_ok_timeout: got no data_ok, expected one within 50 cycles");
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] wd);
    int a0 = acc_cnt;
    int o0 = ok_cnt;
    set_req(a, we, sz, st, wd);
    wait_acc(a0);
    req_valid = 1'b0;
    wait_ok(o0);
  endtask

  initial begin
    int a0, o0, ok1;
    reset = 1'b0;
    set_req(32'h1111_0000, 1'b0, 2'd2, 4'hF, 32'h0);
    repeat (3) tick();
    chk32("reset_rdata_lit", resp_rdata, 32'h0);
    chk1("reset_addr_ok_lit", req_addr_ok, 1'b0);
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Best-case word load.
    cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
    run_txn(32'h1C00_0004, 1'b0, 2'd2, 4'hF, 32'h0);
    chk32("load_latency", 32'(ok_cyc - acc_cyc), 32'd3);
    chk32("load_ar_cycle", 32'(ar_cyc - acc_cyc), 32'd1);
    chk32("load_araddr", ar_addr_rec, 32'h1C00_0004);
    chk32("load_arsize", 32'(ar_sz_rec), 32'd2);
    chk32("load_rdata", ok_rdata, 32'hDEAD_BEEF);
    chk1("load_err", ok_err, 1'b0);

    // Byte store with wready four cycles late.
    aw_wait = 0; w_wait = 3; b_wait = 0; cfg_bresp = 2'b00;
    run_txn(32'h0000_0013, 1'b1, 2'd0, 4'b1000, 32'h5A5A_5A5A);
    chk32("store_wvalid_cycles", 32'(wv_cycles), 32'd4);
    chk32("store_bready_cycle", 32'(b_cyc - acc_cyc), 32'd5);
    chk32("store_latency", 32'(ok_cyc - acc_cyc), 32'd6);
    chk1("store_err", ok_err, 1'b0);
    w_wait = 0;

    // arready stalled 5 cycles while a second request waits.
    ar_wait = 5; cfg_rdata = 32'h0102_0304;
    a0 = acc_cnt; o0 = ok_cnt;
    set_req(32'h8000_0100, 1'b0, 2'd1, 4'hF, 32'h0);
    wait_acc(a0);
    req_addr = 32'h2000_0000;
    repeat (4) tick();
    req_valid = 1'b0;
    wait_ok(o0);
    chk32("stall_accepts", 32'(acc_cnt - a0), 32'd1);
    chk32("stall_latency", 32'(ok_cyc - acc_cyc), 32'd8);
    chk32("stall_araddr", ar_addr_rec, 32'h8000_0100);
    chk32("stall_arsize", 32'(ar_sz_rec), 32'd1);
    chk32("stall_rdata", ok_rdata, 32'h0102_0304);
    ar_wait = 0;

    // Error responses, then a clean one.
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
    run_txn(32'h0000_0100, 1'b0, 2'd2, 4'hF, 32'h0);
    chk1("slverr_load", ok_err, 1'b1);
    cfg_rresp = 2'b00; cfg_rdata = 32'h8765_4321;
    run_txn(32'h0000_0104, 1'b0, 2'd2, 4'hF, 32'h0);
    chk1("ok_load_after_err", ok_err, 1'b0);
    chk32("ok_load_rdata", ok_rdata, 32'h8765_4321);
    cfg_bresp = 2'b11;
    run_txn(32'h0000_0108, 1'b1, 2'd2, 4'hF, 32'hA5A5_0F0F);
    chk1("decerr_store", ok_err, 1'b1);
    cfg_bresp = 2'b00;

    // Back-to-back with req_valid held high.
    cfg_rdata = 32'h0000_0040;
    a0 = acc_cnt; o0 = ok_cnt;
    set_req(32'h0000_0040, 1'b0, 2'd2, 4'hF, 32'h0);
    wait_ok(o0);
    ok1 = ok_cyc;
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    chk32("b2b_second_accept", 32'(acc_cyc - ok1), 32'd1);
    wait_ok(o0 + 1);
    chk32("b2b_accepts", 32'(acc_cnt - a0), 32'd2);

    // Reset asserted while the write channels are stalled.
    aw_wait = 20; w_wait = 20;
    a0 = acc_cnt; o0 = ok_cnt;
    set_req(32'h0000_0200, 1'b1, 2'd2, 4'hF, 32'hCAFE_F00D);
    wait_acc(a0);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk1("midrst_awvalid", awvalid, 1'b0);
    chk1("midrst_wvalid", wvalid, 1'b0);
    chk1("midrst_bready", bready, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    aw_wait = 0; w_wait = 0;
    tick();
    cfg_rdata = 32'h0BAD_F00D;
    run_txn(32'h1C00_0008, 1'b0, 2'd2, 4'hF, 32'h0);
    chk32("post_rst_latency", 32'(ok_cyc - acc_cyc), 32'd3);
    chk32("post_rst_rdata", ok_rdata, 32'h0BAD_F00D);
    chk32("post_rst_ok_count", 32'(ok_cnt - o0), 32'd1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected it within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_axi_resp.md
# mem_axi_resp

Responder end of the data-side memory request interface driven by the MEM-stage controller: accepts one `valid/addr/we/size/wstrb/wdata` request per `addr_ok` handshake and returns completion via `data_ok`/`rdata`. Translates each request into a single-beat AXI4 read (AR/R) or write (AW/W/B) transaction, with at most one transaction outstanding. Sits between the MMU's physical-address output and the top-level AXI crossbar.

## Interface
Parameters:
- AXI_ID, default 4'd1, constant ARID/AWID for data-side traffic.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  request present.
- req_addr  in  32  physical byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word.
- req_wstrb  in  4  byte enables (stores only).
- req_wdata  in  32  store data, already lane-replicated by the initiator.
- req_addr_ok  out  1  request accepted this cycle.
- resp_data_ok  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data, valid when resp_data_ok && the request was a load.
- resp_err  out  1  SLVERR/DECERR on the completed transaction, valid with resp_data_ok.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1;  arready in 1.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1;  rready out 1.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1;  awready in 1.
- wdata/wstrb/wlast/wvalid  out  32/4/1/1;  wready in 1.
- bid/bresp/bvalid  in  4/2/1;  bready out 1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_addr_ok = req_valid (combinational). On accept, latch addr/we/size/wstrb/wdata; go to RD_ADDR (we=0) or WR_REQ (we=1).
- RD_ADDR: arvalid=1; araddr/arsize from latch; on arready -> RD_DATA.
- RD_DATA: rready=1; on rvalid capture rdata, err = (rresp != 0) -> DONE. rid/rlast not checked.
- WR_REQ: awvalid and wvalid raised together; per-channel done flags aw_done, w_done; each valid drops after its own handshake; when both done (same or different cycles) -> WR_RESP.
- WR_RESP: bready=1; on bvalid, err = (bresp != 0) -> DONE.
- DONE: resp_data_ok=1 for exactly one cycle, resp_rdata/resp_err from registers; req_addr_ok=0; -> IDLE.
- Constants: arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arsize=awsize={1'b0,latched size}.
- No cancellation: an accepted request always completes through DONE; the initiator discards unwanted responses.
- AXI valid signals, once raised, stay asserted and payload stable until handshake (AXI rule).
- req_size=3 is illegal input; behaviour unspecified.

## Timing
- Reset (async, reset=0): state=IDLE, aw_done=w_done=0; arvalid, awvalid, wvalid, rready, bready, resp_data_ok, resp_err = 0; resp_rdata=0; req_addr_ok forced 0 while reset=0.
- Best-case load: accept cycle T; arvalid T+1 (arready=1); rvalid T+2; data_ok T+3. Best-case store: accept T; aw/w handshake T+1; bvalid T+2; data_ok T+3.
- Next request accepted no earlier than cycle after DONE (T+4 best case).
- rvalid/bvalid asserted in the state before RD_DATA/WR_RESP are ignored (rready/bready=0).
- Reset asserted mid-transaction: return to IDLE immediately; outstanding AXI transaction abandoned (system reset resets both ends).

## Test plan
- Load word 0x1C00_0004, arready=1, rvalid next cycle with rdata=0xDEAD_BEEF, rresp=0 -> addr_ok at T, araddr=0x1C00_0004/arsize=2 at T+1, data_ok at T+3 with rdata=0xDEAD_BEEF, err=0.
- Store byte addr 0x0000_0013, wstrb=4'b1000, wdata=0x5A5A_5A5A; awready at T+1, wready delayed to T+4 -> awvalid drops after T+1, wvalid held T+1..T+4, bready from T+5, data_ok one cycle after bvalid.
- arready held 0 for 5 cycles -> arvalid and araddr stable all 5 cycles; no data_ok; req_addr_ok=0 for a second req_valid.
- Load with rresp=2'b10 -> data_ok with resp_err=1; next load with rresp=0 -> resp_err=0.
- Back-to-back req_valid held high -> exactly one accept per transaction; second addr_ok the cycle after first data_ok.
- reset dropped to 0 during WR_REQ -> all AXI valids and ready outputs 0 immediately; after release, new load completes normally.
